// File: rtl/sha512_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sha512_job_scheduler
// Description : Shares one SHA-512 core between two requesters. A round-robin
//               arbiter grants the core to one requester. The scheduler then
//               streams 32 message words into the core text port and issues
//               the start command. It waits for the core to go busy and then
//               idle, issues the read command and streams 16 digest words
//               back to the owner before it releases the grant.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                   clock, rising edge
//   rst                   synchronous reset, active low
//   req_i[1:0]            per-requester job request (level)
//   gnt_o[1:0]            one-hot owner of the core, zero when idle
//   in_valid_i/in_data_i/in_ready_o
//                         message-word stream from the owner (32 words)
//   out_valid_o/out_data_o/out_last_o/out_ready_i
//                         digest-word stream to the owner (16 words)
//   err_o                 one-cycle pulse when a WAIT timeout aborts a job
//   core_text_o/core_cmd_o/core_cmd_w_o
//                         core text input, command code, command write
//   core_text_i/core_busy_i
//                         core text output and busy flag
// Configuration
//   SHA_SCHED_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT cycles and
//                         an expired bound pulses err_o and skips the read-out.
//                         When undefined, WAIT is unbounded and err_o is 0.
// Core read-out model
//   After CMD_READ the core presents digest word 0 on core_text_i. It steps
//   to the next word on each consumed out word (out_valid_o & out_ready_i),
//   so the core advances only on consumption.
// ============================================================================
module sha512_job_scheduler #(
    parameter logic [3:0] CMD_START = 4'h1,
    parameter logic [3:0] CMD_READ  = 4'h2,
    parameter int         TIMEOUT   = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    input  logic        out_ready_i,
    output logic        err_o,
    output logic [31:0] core_text_o,
    output logic [3:0]  core_cmd_o,
    output logic        core_cmd_w_o,
    input  logic [31:0] core_text_i,
    input  logic        core_busy_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q;
    logic [1:0]  gnt_q;
    logic        owner_q;      // index of the current owner
    logic        last_q;       // index of the previous owner (round-robin)
    logic [4:0]  word_cnt_q;   // message words captured in LOAD
    logic [3:0]  dig_cnt_q;    // digest word currently being presented
    logic        seen_busy_q;  // core has reported busy since START
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        out_last_q;
    logic [31:0] core_text_q;
    logic [3:0]  core_cmd_q;
    logic        core_cmd_w_q;

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              err_q;
`endif

    // Requester chosen in IDLE. If both requesters ask, the one that did not
    // own the core last time wins. Otherwise the single asker wins.
    logic owner_d;
    assign owner_d = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;   // requester 0 wins the first tie
            word_cnt_q   <= 5'd0;
            dig_cnt_q    <= 4'd0;
            seen_busy_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'd0;
            out_last_q   <= 1'b0;
            core_text_q  <= 32'd0;
            core_cmd_q   <= 4'd0;
            core_cmd_w_q <= 1'b0;
`ifdef SHA_SCHED_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            // Command writes and the error flag are single-cycle pulses.
            // They are cleared here and set again only by the cycle that
            // issues them.
            core_cmd_w_q <= 1'b0;
`ifdef SHA_SCHED_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        owner_q    <= owner_d;
                        gnt_q      <= owner_d ? 2'b10 : 2'b01;
                        word_cnt_q <= 5'd0;
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end

                LOAD: begin
                    if (in_valid_i && in_ready_q) begin
                        core_text_q <= in_data_i;
                        if (word_cnt_q == 5'd31) begin
                            // The 32nd word closes the block. The counter is
                            // cleared here and never rolls over by itself.
                            // The start command is raised now so that it is
                            // visible for the whole START cycle.
                            word_cnt_q   <= 5'd0;
                            in_ready_q   <= 1'b0;
                            core_cmd_q   <= CMD_START;
                            core_cmd_w_q <= 1'b1;
                            state_q      <= START;
                        end else begin
                            word_cnt_q <= word_cnt_q + 5'd1;
                        end
                    end
                end

                START: begin
                    seen_busy_q <= 1'b0;
`ifdef SHA_SCHED_TIMEOUT_EN
                    wait_cnt_q  <= '0;
`endif
                    state_q     <= WAIT;
                end

                WAIT: begin
                    if (core_busy_i) begin
                        seen_busy_q <= 1'b1;
                    end
                    // Completion means busy was seen and has now dropped.
                    // A core that never raises busy keeps the job here.
                    if (seen_busy_q && !core_busy_i) begin
                        core_cmd_q   <= CMD_READ;
                        core_cmd_w_q <= 1'b1;
                        dig_cnt_q    <= 4'd0;
                        state_q      <= READ;
                    end
`ifdef SHA_SCHED_TIMEOUT_EN
                    else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        gnt_q   <= 2'b00;
                        state_q <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
`endif
                end

                READ: begin
                    if (out_valid_q) begin
                        // Hold data and valid until consumed
                        if (out_ready_i) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            if (dig_cnt_q == 4'd15) begin
                                dig_cnt_q <= 4'd0;
                                gnt_q     <= 2'b00;
                                state_q   <= DONE;
                            end else begin
                                dig_cnt_q <= dig_cnt_q + 4'd1;
                            end
                        end
                    end else if (!core_cmd_w_q) begin
                        // The core text is not valid during the read command
                        // cycle. After that cycle, and after each consumption,
                        // the next digest word is fetched into the output
                        // register.
                        out_data_q  <= core_text_i;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (dig_cnt_q == 4'd15);
                    end
                end

                DONE: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign core_text_o  = core_text_q;
    assign core_cmd_o   = core_cmd_q;
    assign core_cmd_w_o = core_cmd_w_q;

`ifdef SHA_SCHED_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha512_job_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sha512_job_scheduler
// Description : Self-checking bench for sha512_job_scheduler. It applies a
//               table of directed jobs, then randomized jobs, then a
//               reset-in-WAIT sequence and a stuck-busy sequence. A small
//               core model supplies the busy flag and the digest words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha512_job_scheduler;

    localparam logic [3:0] C_START = 4'h1;
    localparam logic [3:0] C_READ  = 4'h2;

    logic        clk;
    logic        rst;
    logic [1:0]  req_i;
    logic [1:0]  gnt_o;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic        err_o;
    logic [31:0] core_text_o;
    logic [3:0]  core_cmd_o;
    logic        core_cmd_w_o;
    logic [31:0] core_text_i;
    logic        core_busy_i;

    sha512_job_scheduler #(
        .CMD_START (C_START),
        .CMD_READ  (C_READ),
        .TIMEOUT   (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i),
        .err_o        (err_o),
        .core_text_o  (core_text_o),
        .core_cmd_o   (core_cmd_o),
        .core_cmd_w_o (core_cmd_w_o),
        .core_text_i  (core_text_i),
        .core_busy_i  (core_busy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    logic rr_last;   // model: index of the previous owner

    typedef struct {
        logic [1:0]  req;
        bit          drop;        // owner lowers req after the grant
        int          gap_mode;    // 0 always valid, 1 every other cycle, 2 random
        int          busy;        // cycles the core stays busy
        int          stall_word;  // digest word held back by out_ready_i=0
        int          stall_len;
        bit          rand_ready;
        logic [31:0] base;
        logic [1:0]  exp_gnt;
    } job_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] digest_word(input logic [31:0] base, input int k);
        return (base * 32'h01000193) ^ (32'hA5A50000 + 32'(k) * 32'h9E3779B9);
    endfunction

    // Round-robin reference: a lone requester wins. On a tie, the requester
    // that did not own the core last time wins.
    function automatic logic [1:0] rr_expect(input logic [1:0] r, input logic last);
        if (r == 2'b11) return last ? 2'b01 : 2'b10;
        return r;
    endfunction

    function automatic logic [127:0] reset_vec();
        return {gnt_o, in_ready_o, out_valid_o, out_last_o, out_data_o,
                core_text_o, core_cmd_o, core_cmd_w_o, err_o};
    endfunction

    // Runs one complete job. Outputs are sampled and inputs are driven on
    // the falling edge.
    task automatic run_job(input job_t j);
        int cyc, nin, nout, start_w, read_w, last_cnt, busy_left, stall_left, idx;
        int text_err, data_err, stab_err, misc_err;
        bit pend_in, pend_out, busy_delay, done, prev_stall, tog;
        logic [31:0] held;
        cyc = 0; nin = 0; nout = 0; start_w = 0; read_w = 0; last_cnt = 0;
        busy_left = 0; stall_left = j.stall_len; idx = 0;
        text_err = 0; data_err = 0; stab_err = 0; misc_err = 0;
        pend_in = 0; pend_out = 0; busy_delay = 0; done = 0; prev_stall = 0; tog = 0;
        held = '0;
        core_busy_i = 1'b0;
        req_i = j.req;
        while (gnt_o == 2'b00 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant", gnt_o, j.exp_gnt);
        if (j.drop) req_i = 2'b00;
        while (!done && cyc < 5000) begin
            // Handshakes that completed at the last rising edge
            if (pend_in) begin
                if (core_text_o !== j.base + 32'(nin)) text_err++;
                nin++;
            end
            if (pend_out) begin
                nout++;
                idx++;
                core_text_i = digest_word(j.base, idx);
            end
            if (err_o) misc_err++;
            if (gnt_o == 2'b00) begin
                done = 1;
            end else begin
                if (gnt_o !== j.exp_gnt) misc_err++;
                if (core_cmd_w_o) begin
                    if (core_cmd_o == C_START) begin
                        start_w++;
                        if (nin != 32) misc_err++;
                        busy_left = j.busy;
                        busy_delay = 1;
                    end else if (core_cmd_o == C_READ) begin
                        read_w++;
                        idx = 0;
                        core_text_i = digest_word(j.base, 0);
                    end else begin
                        misc_err++;
                    end
                end
                if (in_ready_o && nin >= 32) misc_err++;
                if (out_valid_o) begin
                    if (out_data_o !== digest_word(j.base, nout)) data_err++;
                    if (out_last_o !== (nout == 15)) data_err++;
                    if (prev_stall && out_data_o !== held) stab_err++;
                end else if (prev_stall) begin
                    stab_err++;
                end
            end
            if (!done) begin
                tog = ~tog;
                in_data_i = j.base + 32'(nin);
                case (j.gap_mode)
                    0:       in_valid_i = (nin < 32);
                    1:       in_valid_i = (nin < 32) && tog;
                    default: in_valid_i = (nin < 32) && ($urandom_range(0, 1) == 1);
                endcase
                pend_in = in_valid_i && in_ready_o;
                if (busy_delay) busy_delay = 0;
                else if (busy_left > 0) begin core_busy_i = 1'b1; busy_left--; end
                else core_busy_i = 1'b0;
                if (out_valid_o && nout == j.stall_word && stall_left > 0) begin
                    out_ready_i = 1'b0;
                    stall_left--;
                end else if (j.rand_ready) begin
                    out_ready_i = ($urandom_range(0, 3) != 0);
                end else begin
                    out_ready_i = 1'b1;
                end
                pend_out = out_valid_o && out_ready_i;
                if (pend_out && out_last_o) last_cnt++;
                prev_stall = out_valid_o && !out_ready_i;
                held = out_data_o;
                @(negedge clk);
                cyc++;
            end
        end
        in_valid_i  = 1'b0;
        core_busy_i = 1'b0;
        chk("job_finished", done, 1);
        chk("words_in", nin, 32);
        chk("words_out", nout, 16);
        chk("start_writes", start_w, 1);
        chk("read_writes", read_w, 1);
        chk("last_count", last_cnt, 1);
        chk("text_errors", text_err, 0);
        chk("digest_errors", data_err, 0);
        chk("stall_errors", stab_err, 0);
        chk("protocol_errors", misc_err, 0);
        chk("done_outputs", {in_ready_o, out_valid_o, core_cmd_w_o}, 3'b000);
        rr_last = j.exp_gnt[1];
    endtask

    // Grants a job and streams words until the start command appears.
    task automatic feed_to_start(input logic [31:0] base, output bit ok);
        int cyc, n;
        cyc = 0; n = 0; ok = 0;
        while (gnt_o == 2'b00 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        while (!ok && cyc < 500) begin
            if (core_cmd_w_o && core_cmd_o == C_START) begin
                ok = 1;
            end else begin
                in_valid_i = (n < 32);
                in_data_i  = base + 32'(n);
                if (in_valid_i && in_ready_o) n++;
                @(negedge clk);
                cyc++;
            end
        end
        in_valid_i = 1'b0;
    endtask

    job_t tbl[6];
    job_t rj;

    initial begin
        int cnt, reads, errs;
        bit ok;
        rst = 1'b0; req_i = 2'b00; in_valid_i = 1'b0; in_data_i = '0;
        out_ready_i = 1'b0; core_text_i = '0; core_busy_i = 1'b0;
        rr_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", reset_vec(), '0);
        rst = 1'b1;
        @(negedge clk);

        //        req    drop  gap busy stall len rand  base        gnt
        tbl[0] = '{2'b11, 1'b0, 0, 10, -1, 0, 1'b0, 32'd100,    2'b01};
        tbl[1] = '{2'b11, 1'b0, 2, 20, -1, 0, 1'b1, 32'd200,    2'b10};
        tbl[2] = '{2'b11, 1'b0, 0,  5, -1, 0, 1'b0, 32'd300,    2'b01};
        tbl[3] = '{2'b01, 1'b1, 0, 80, -1, 0, 1'b0, 32'd0,      2'b01};
        tbl[4] = '{2'b10, 1'b0, 1,  3, -1, 0, 1'b0, 32'h1000,   2'b10};
        tbl[5] = '{2'b01, 1'b0, 0,  7,  3, 5, 1'b0, 32'h2000,   2'b01};
        for (int i = 0; i < 6; i++) run_job(tbl[i]);

        for (int r = 0; r < 6; r++) begin
            rj.req        = 2'($urandom_range(1, 3));
            rj.drop       = ($urandom_range(0, 1) == 1);
            rj.gap_mode   = 2;
            rj.busy       = $urandom_range(1, 40);
            rj.stall_word = $urandom_range(0, 15);
            rj.stall_len  = $urandom_range(0, 6);
            rj.rand_ready = 1'b1;
            rj.base       = $urandom;
            rj.exp_gnt    = rr_expect(rj.req, rr_last);
            run_job(rj);
        end

        // Reset while the core is busy, then a fresh job for requester 1
        req_i = 2'b01;
        feed_to_start(32'h3000, ok);
        chk("reach_start_a", ok, 1);
        core_busy_i = 1'b1;
        req_i = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_wait", reset_vec(), '0);
        rst = 1'b1;
        core_busy_i = 1'b0;
        rr_last = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (core_cmd_w_o || gnt_o != 2'b00) cnt++;
        end
        chk("quiet_after_reset", cnt, 0);
        rj = '{2'b10, 1'b0, 0, 4, -1, 0, 1'b0, 32'h0, 2'b10};
        run_job(rj);
        req_i = 2'b00;

        // Busy stuck high
        req_i = 2'b01;
        feed_to_start(32'h4000, ok);
        chk("reach_start_b", ok, 1);
        req_i = 2'b00;
        core_busy_i = 1'b1;
        reads = 0;
`ifdef SHA_SCHED_TIMEOUT_EN
        cnt = 0;
        while (!err_o && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (core_cmd_w_o && core_cmd_o == C_READ) reads++;
        end
        chk("timeout_wait_cycles", cnt - 1, 200);
        chk("timeout_gnt_drop", gnt_o, 2'b00);
        chk("timeout_no_read", reads, 0);
        @(negedge clk);
        chk("timeout_err_pulse", {err_o, gnt_o, out_valid_o}, 4'b0000);
        core_busy_i = 1'b0;
`else
        errs = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (core_cmd_w_o && core_cmd_o == C_READ) reads++;
            if (err_o || out_valid_o || in_ready_o) errs++;
        end
        chk("stuck_still_granted", gnt_o, 2'b01);
        chk("stuck_no_read", reads, 0);
        chk("stuck_quiet", errs, 0);
        core_busy_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("stuck_reset", reset_vec(), '0);
        rst = 1'b1;
`endif
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha512_job_scheduler.md
SHA512_JOB_SCHEDULER -- requirements
Module: sha512_job_scheduler

Interface
REQ-001 SHALL have parameter CMD_START, default 4'h1, command code written to the core to start a block.
REQ-002 SHALL have parameter CMD_READ, default 4'h2, command code written to the core to begin the digest read-out.
REQ-003 SHALL have parameter TIMEOUT, default 200, maximum cycles in WAIT (only when SHA_SCHED_TIMEOUT_EN is defined).
REQ-004 clk  in  1  clock; all logic samples on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_i  in  2  per-requester job request, level.
REQ-007 gnt_o  out  2  one-hot owner of the core; all-zero when idle.
REQ-008 in_valid_i / in_data_i / in_ready_o  in 1 / in 32 / out 1  message-word stream from the granted requester.
REQ-009 out_valid_o / out_data_o / out_last_o / out_ready_i  out 1 / out 32 / out 1 / in 1  digest-word stream to the granted requester.
REQ-010 err_o  out  1  one-cycle pulse on timeout abort; tied 0 without the macro.
REQ-011 core_text_o / core_cmd_o / core_cmd_w_o  out 32 / out 4 / out 1  drive core text, command and command-write inputs.
REQ-012 core_text_i / core_busy_i  in 32 / in 1  core text output and busy flag.

Function
REQ-013 SHALL use FSM states IDLE, LOAD, START, WAIT, READ, DONE.
REQ-014 IDLE: if any req_i is set, SHALL grant one requester (round-robin, the requester not granted last wins ties) and enter LOAD in the next cycle; gnt_o stays constant until DONE.
REQ-015 LOAD: in_ready_o=1; each in_valid_i&in_ready_o cycle SHALL copy in_data_i to core_text_o and increment a 5-bit word counter; after the 32nd word, go to START.
REQ-016 START: SHALL assert core_cmd_w_o for exactly one cycle with core_cmd_o=CMD_START, then go to WAIT.
REQ-017 WAIT: SHALL first observe core_busy_i=1, then on the first cycle with core_busy_i=0 go to READ; busy never going high holds WAIT (no timeout without the macro).
REQ-018 READ entry: SHALL pulse core_cmd_w_o for one cycle with core_cmd_o=CMD_READ, then present 16 digest words from core_text_i.
REQ-019 READ: a word is consumed on out_valid_o&out_ready_i; the core SHALL advance only on consumption; out_last_o=1 on word 16 only; out_data_o SHALL be held stable while out_ready_i=0.
REQ-020 DONE: SHALL drop gnt_o for one cycle, record the last owner, and return to IDLE; back-to-back grants to one requester therefore have at least one idle cycle between them.
REQ-021 req_i deassertion by the owner mid-job SHALL be ignored; the job runs to completion.
REQ-022 in_ready_o, out_valid_o and core_cmd_w_o SHALL be 0 in every state other than those stated above.
REQ-023 Word and digest counters SHALL wrap only via explicit reset on state entry, never by overflow.

Reset
REQ-024 With rst=0 at a clock edge: state=IDLE, gnt_o=0, in_ready_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, core_text_o=0, core_cmd_o=0, core_cmd_w_o=0, err_o=0, counters=0, last-owner=1 (requester 0 wins first).
REQ-025 Reset mid-job SHALL abandon the job without a digest; the core SHALL see no further cmd writes.

Configuration
REQ-026 Macro SHA_SCHED_TIMEOUT_EN defined: a WAIT-cycle counter SHALL, on reaching TIMEOUT, pulse err_o for one cycle and go to DONE without a READ.
REQ-027 Macro undefined: no counter is built, err_o=0 constant, and WAIT is unbounded.

Verification
REQ-028 Reset, req_i=2'b01, 32 words 0..31, busy high 80 cycles -> gnt_o=01, one CMD_START write, then CMD_READ write, 16 out words with out_last_o on the 16th, gnt_o=00 in DONE.
REQ-029 req_i=2'b11 held across three jobs -> gnt_o sequence 01, 10, 01.
REQ-030 in_valid_i toggled every other cycle in LOAD -> exactly 32 captures, START after the 32nd valid only.
REQ-031 out_ready_i=0 for 5 cycles on word 3 -> out_data_o stable, no word lost or duplicated, 16 words total.
REQ-032 rst=0 during WAIT, then req_i=2'b10 -> all outputs at reset values, fresh job granted to requester 1, starting LOAD from word 0.
REQ-033 With SHA_SCHED_TIMEOUT_EN, TIMEOUT=200, busy stuck 1 -> err_o pulse at WAIT cycle 200, no CMD_READ, return to IDLE; without the macro, still in WAIT at cycle 1000.
